// File: rtl/rr_reg_arbiter_if.sv
// Bundle of requester-side and downstream-side handshake signals for
// rr_reg_arbiter. The master side drives requests and the downstream accept,
// and the slave side (the arbiter) drives grants, the output register and
// the transfer count.
interface rr_reg_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  localparam int SRC_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          out_valid;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [SRC_WIDTH-1:0]          out_src;
  logic                          out_ready;
  logic [CNT_WIDTH-1:0]          xfer_count;

  // Requesters plus downstream consumer.
  modport master (
    output req_valid,
    output req_data,
    input  req_ready,
    input  out_valid,
    input  out_data,
    input  out_src,
    output out_ready,
    input  xfer_count
  );

  // The arbiter itself.
  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready,
    output out_valid,
    output out_data,
    output out_src,
    input  out_ready,
    output xfer_count
  );
endinterface

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter feeding a single-entry output register.
// Requesters are searched starting at the priority pointer and wrapping
// around; the winner is granted whenever the register is empty or is being
// drained in the same cycle, giving one transfer per cycle with no bubbles.
// The pointer advances past the winner only on an accept, so idle cycles and
// stalls never shift priority. rst_n is active-high and asynchronous.
module rr_reg_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  localparam int SRC_WIDTH = $clog2(NUM_REQ)
) (
  input logic             clk,
  input logic             rst_n,
  rr_reg_arbiter_if.slave bus
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [SRC_WIDTH-1:0] LAST_IDX = SRC_WIDTH'(NUM_REQ - 1);

  // Registered state.
  logic [0:0]            state_q, state_d;
  logic [SRC_WIDTH-1:0]  ptr_q,   ptr_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic [SRC_WIDTH-1:0]  src_q,   src_d;
  logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;

  // Requester words unpacked from the flat bus.
  logic [DATA_WIDTH-1:0] req_word [NUM_REQ];

  // Requests at or above the pointer take precedence over the wrapped ones.
  logic [NUM_REQ-1:0]    upper_mask;
  logic [NUM_REQ-1:0]    upper_req;

  logic                  upper_found;
  logic [SRC_WIDTH-1:0]  upper_idx;
  logic                  any_found;
  logic [SRC_WIDTH-1:0]  any_idx;

  logic                  winner_valid;
  logic [SRC_WIDTH-1:0]  winner_idx;
  logic                  can_accept;
  logic                  grant;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_word[gi]   = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign upper_mask[gi] = (gi >= int'(ptr_q));
      // Grant is one-hot on the winner and suppressed while reset is held.
      assign bus.req_ready[gi] = grant && (winner_idx == SRC_WIDTH'(gi));
    end
  endgenerate

  assign upper_req = bus.req_valid & upper_mask;

  // Lowest-index set bit in the upper (pointer and above) group and overall;
  // scanning downward lets the lowest index overwrite any higher match.
  always_comb begin
    upper_found = 1'b0;
    upper_idx   = '0;
    any_found   = 1'b0;
    any_idx     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (upper_req[i]) begin
        upper_found = 1'b1;
        upper_idx   = SRC_WIDTH'(i);
      end
      if (bus.req_valid[i]) begin
        any_found = 1'b1;
        any_idx   = SRC_WIDTH'(i);
      end
    end
  end

  // If nothing is pending from the pointer upward, the search wraps to the
  // lowest valid index below the pointer.
  assign winner_valid = any_found;
  assign winner_idx   = upper_found ? upper_idx : any_idx;

  // The register can take new data when empty or when it drains this cycle.
  assign can_accept = (state_q == ST_EMPTY) || bus.out_ready;
  assign grant      = winner_valid && can_accept && !rst_n;

  // Next-state: load on accept, otherwise empty out on a drain-only cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    if (grant) begin
      state_d = ST_FULL;
      data_d  = req_word[winner_idx];
      src_d   = winner_idx;
      ptr_d   = (winner_idx == LAST_IDX) ? '0 : winner_idx + 1'b1;
      cnt_d   = cnt_q + 1'b1;
    end else if ((state_q == ST_FULL) && bus.out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // State registers; reset clears everything immediately and discards any
  // word waiting in the output register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid  = (state_q == ST_FULL);
  assign bus.out_data   = data_q;
  assign bus.out_src    = src_q;
  assign bus.xfer_count = cnt_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed bench for rr_reg_arbiter: a 4-requester/16-bit-count instance and
// a 3-requester/4-bit-count instance share clock and reset. Expected output
// words are queued when a grant is expected and compared when the output
// register should present them.
module tb_rr_reg_arbiter;

  typedef struct packed {
    logic [7:0]  data;
    logic [1:0]  src;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_reg_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8), .CNT_WIDTH(16)) bus_a ();
  rr_reg_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(8), .CNT_WIDTH(4))  bus_b ();

  rr_reg_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .CNT_WIDTH(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  rr_reg_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .CNT_WIDTH(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  int checks = 0;
  int errors = 0;
  int cnt_a  = 0;
  int cnt_b  = 0;
  logic [7:0] da [4];
  logic [7:0] db [3];
  exp_t sb_a [$];
  exp_t sb_b [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  // One cycle on instance A: drive at negedge, check grant, check output after posedge.
  task automatic step_a(input logic [3:0] valid, input logic ordy, input logic [3:0] exp_rdy, input string tag);
    exp_t e;
    @(negedge clk);
    bus_a.req_valid = valid;
    bus_a.req_data  = {da[3], da[2], da[1], da[0]};
    bus_a.out_ready = ordy;
    #1;
    check({tag, ".ready"}, 32'(bus_a.req_ready), 32'(exp_rdy));
    if (exp_rdy != 4'b0) begin
      cnt_a++;
      e.data = da[oh_idx(exp_rdy)];
      e.src  = 2'(oh_idx(exp_rdy));
      e.cnt  = 16'(cnt_a);
      sb_a.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sb_a.size() != 0) begin
      e = sb_a.pop_front();
      check({tag, ".valid"}, 32'(bus_a.out_valid), 32'd1);
      check({tag, ".data"},  32'(bus_a.out_data),  32'(e.data));
      check({tag, ".src"},   32'(bus_a.out_src),   32'(e.src));
      check({tag, ".count"}, 32'(bus_a.xfer_count), 32'(e.cnt));
    end
    $display("A %s valid=%b ordy=%b ready=%b out_valid=%b data=%02h src=%0d count=%0d",
             tag, valid, ordy, bus_a.req_ready, bus_a.out_valid, bus_a.out_data, bus_a.out_src, bus_a.xfer_count);
  endtask

  // Same for instance B (3 requesters, 4-bit count).
  task automatic step_b(input logic [2:0] valid, input logic ordy, input logic [2:0] exp_rdy, input string tag);
    exp_t e;
    @(negedge clk);
    bus_b.req_valid = valid;
    bus_b.req_data  = {db[2], db[1], db[0]};
    bus_b.out_ready = ordy;
    #1;
    check({tag, ".ready"}, 32'(bus_b.req_ready), 32'(exp_rdy));
    if (exp_rdy != 3'b0) begin
      cnt_b++;
      e.data = db[oh_idx({1'b0, exp_rdy})];
      e.src  = 2'(oh_idx({1'b0, exp_rdy}));
      e.cnt  = 16'(cnt_b % 16);
      sb_b.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sb_b.size() != 0) begin
      e = sb_b.pop_front();
      check({tag, ".valid"}, 32'(bus_b.out_valid), 32'd1);
      check({tag, ".data"},  32'(bus_b.out_data),  32'(e.data));
      check({tag, ".src"},   32'(bus_b.out_src),   32'(e.src));
      check({tag, ".count"}, 32'(bus_b.xfer_count), 32'(e.cnt));
    end
    $display("B %s valid=%b ordy=%b ready=%b out_valid=%b data=%02h src=%0d count=%0d",
             tag, valid, ordy, bus_b.req_ready, bus_b.out_valid, bus_b.out_data, bus_b.out_src, bus_b.xfer_count);
  endtask

  initial begin
    bus_a.req_valid = '0; bus_a.req_data = '0; bus_a.out_ready = 1'b0;
    bus_b.req_valid = '0; bus_b.req_data = '0; bus_b.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) da[i] = 8'h00;
    for (int i = 0; i < 3; i++) db[i] = 8'h40 + 8'(i);
    #1 rst_n = 1'b1;

    // Reset state, with requests present: no grant while reset is held.
    @(posedge clk); @(negedge clk);
    bus_a.req_valid = 4'b1111; bus_a.out_ready = 1'b1;
    #1;
    check("rst.valid", 32'(bus_a.out_valid), 32'd0);
    check("rst.data",  32'(bus_a.out_data),  32'd0);
    check("rst.count", 32'(bus_a.xfer_count), 32'd0);
    check("rst.ready", 32'(bus_a.req_ready), 32'd0);
    @(negedge clk);
    bus_a.req_valid = '0;
    rst_n = 1'b0;

    // Test 1: fill the register with 0x3C, then reset asynchronously mid-cycle.
    da[0] = 8'h3C;
    step_a(4'b0001, 1'b0, 4'b0001, "t1.fill");
    bus_a.req_valid = 4'b1111;
    #1 rst_n = 1'b1;
    #1;
    check("t1.async_valid", 32'(bus_a.out_valid), 32'd0);
    check("t1.async_data",  32'(bus_a.out_data),  32'd0);
    check("t1.async_count", 32'(bus_a.xfer_count), 32'd0);
    check("t1.async_ready", 32'(bus_a.req_ready), 32'd0);
    @(negedge clk);
    bus_a.req_valid = '0;
    rst_n = 1'b0;
    cnt_a = 0;

    // Test 2: single requester 2, then drain with no further requests.
    da[2] = 8'hA5;
    step_a(4'b0100, 1'b1, 4'b0100, "t2.acc");
    step_a(4'b0000, 1'b1, 4'b0000, "t2.drain");
    check("t2.empty", 32'(bus_a.out_valid), 32'd0);
    check("t2.hold",  32'(bus_a.out_data),  32'hA5);

    // Test 3: fresh pointer, all four continuously valid -> 0,1,2,3,0,1.
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) rst_n = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 4; i++) da[i] = 8'h10 + 8'(i);
    step_a(4'b1111, 1'b1, 4'b0001, "t3.0");
    step_a(4'b1111, 1'b1, 4'b0010, "t3.1");
    step_a(4'b1111, 1'b1, 4'b0100, "t3.2");
    step_a(4'b1111, 1'b1, 4'b1000, "t3.3");
    step_a(4'b1111, 1'b1, 4'b0001, "t3.4");
    step_a(4'b1111, 1'b1, 4'b0010, "t3.5");

    // Test 4: register holds 0x11 from src 1; stall five cycles, then release.
    for (int k = 0; k < 5; k++) begin
      step_a(4'b1111, 1'b0, 4'b0000, $sformatf("t4.stall%0d", k));
      check("t4.stall_valid", 32'(bus_a.out_valid), 32'd1);
      check("t4.stall_data",  32'(bus_a.out_data),  32'h11);
      check("t4.stall_src",   32'(bus_a.out_src),   32'd1);
    end
    step_a(4'b1111, 1'b1, 4'b0100, "t4.release");
    step_a(4'b0000, 1'b1, 4'b0000, "t4.drain");
    check("t4.empty", 32'(bus_a.out_valid), 32'd0);
    check("t4.hold_src", 32'(bus_a.out_src), 32'd2);

    // Test 5: 3-requester instance, pointer wrap after granting index 2.
    step_b(3'b100, 1'b1, 3'b100, "t5.r2");
    step_b(3'b011, 1'b1, 3'b001, "t5.r0");
    step_b(3'b011, 1'b1, 3'b010, "t5.r1");

    // Test 6: keep accepting to 17 transfers; 4-bit count wraps at 16.
    begin
      int g;
      g = 2;
      for (int k = 0; k < 14; k++) begin
        step_b(3'b111, 1'b1, 3'(1 << g), $sformatf("t6.%0d", cnt_b + 1));
        g = (g + 1) % 3;
      end
    end
    check("t6.final_count", 32'(bus_b.xfer_count), 32'd1);
    step_b(3'b000, 1'b1, 3'b000, "t6.drain");
    check("t6.empty", 32'(bus_b.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
